// File: rtl/uart_cmd_parser_if.sv
// Bundle of the byte stream, register-bank and transmitter signals around the
// UART command parser. The parser side uses the master modport; the
// receiver/register-bank/transmitter environment uses the slave modport.
interface uart_cmd_parser_if #(
  parameter int ADDR_WIDTH = 7
);

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_timeout;

  logic [ADDR_WIDTH-1:0] reg_addr;
  logic                  reg_wr_en;
  logic [7:0]            reg_wr_data;
  logic                  reg_rd_en;
  logic [7:0]            reg_rd_data;

  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;

  logic                  busy;
  logic                  cmd_err;

  modport master (
    input  rx_valid, rx_data, rx_timeout, reg_rd_data, tx_ready,
    output reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, tx_valid, tx_data,
           busy, cmd_err
  );

  modport slave (
    output rx_valid, rx_data, rx_timeout, reg_rd_data, tx_ready,
    input  reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, tx_valid, tx_data,
           busy, cmd_err
  );

endinterface

// File: rtl/uart_cmd_parser.sv
// Command parser between the UART receiver and the register bank.
// A packet is a header {rnw, addr}, a length byte, and for writes the data
// bytes. Reads fetch one register at a time from the bank and hand each byte
// to the transmitter through a valid/ready handshake. The address
// auto-increments per byte and wraps at the top of the address space.
module uart_cmd_parser #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_cmd_parser_if.master      bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_WDATA,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_SEND
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                state_q, state_d;
  logic                  rnw_q, rnw_d;
  logic [7:0]            remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic                  reg_wr_en_q, reg_wr_en_d;
  logic [7:0]            reg_wr_data_q, reg_wr_data_d;
  logic                  reg_rd_en_q, reg_rd_en_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  cmd_err_q, cmd_err_d;

  logic                  tx_fire;

  assign tx_fire = tx_valid_q && bus.tx_ready;

  // State and registered outputs; reset clears everything without an error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rnw_q         <= 1'b0;
      remaining_q   <= '0;
      reg_addr_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
      reg_rd_en_q   <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rnw_q         <= rnw_d;
      remaining_q   <= remaining_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_rd_en_q   <= reg_rd_en_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // Next-state decode; an incoming byte takes priority over a timeout pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) state_d = S_LEN;
      end
      S_LEN: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == 8'd0) state_d = S_IDLE;
          else if (rnw_q)          state_d = S_RD_REQ;
          else                     state_d = S_WDATA;
        end else if (bus.rx_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (bus.rx_valid) begin
          if (remaining_q <= 8'd1) state_d = S_IDLE;
        end else if (bus.rx_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_RD_SEND;
      S_RD_SEND: begin
        if (tx_fire) state_d = (remaining_q <= 8'd1) ? S_IDLE : S_RD_REQ;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output strobes; the write address advances the cycle after each write strobe.
  always_comb begin
    rnw_d         = rnw_q;
    remaining_d   = remaining_q;
    reg_addr_d    = reg_wr_en_q ? (reg_addr_q + ADDR_ONE) : reg_addr_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    reg_rd_en_d   = (state_d == S_RD_REQ) && (state_q != S_RD_REQ);
    tx_valid_d    = tx_valid_q;
    tx_data_d     = tx_data_q;
    cmd_err_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          rnw_d      = bus.rx_data[7];
          reg_addr_d = bus.rx_data[ADDR_WIDTH-1:0];
        end
      end
      S_LEN: begin
        if (bus.rx_valid)        remaining_d = bus.rx_data;
        else if (bus.rx_timeout) cmd_err_d   = 1'b1;
      end
      S_WDATA: begin
        if (bus.rx_valid) begin
          reg_wr_en_d   = 1'b1;
          reg_wr_data_d = bus.rx_data;
          if (remaining_q != 8'd0) remaining_d = remaining_q - 8'd1;
        end else if (bus.rx_timeout) begin
          cmd_err_d = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (bus.rx_valid) cmd_err_d = 1'b1;
      end
      S_RD_WAIT: begin
        if (bus.rx_valid) cmd_err_d = 1'b1;
        tx_data_d  = bus.reg_rd_data;
        tx_valid_d = 1'b1;
      end
      S_RD_SEND: begin
        if (bus.rx_valid) cmd_err_d = 1'b1;
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          reg_addr_d = reg_addr_q + ADDR_ONE;
          if (remaining_q != 8'd0) remaining_d = remaining_q - 8'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.reg_addr    = reg_addr_q;
  assign bus.reg_wr_en   = reg_wr_en_q;
  assign bus.reg_wr_data = reg_wr_data_q;
  assign bus.reg_rd_en   = reg_rd_en_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.cmd_err     = cmd_err_q;

endmodule
